dmem_arbiter: RTL and testbench

// - Shares the single data-memory port between two requesters: the CPU memory stage (CPU) and an auxiliary loader/debug master (AUX).
// - Sits between the M-stage signals and the data memory; returns read data with a fixed latency and raises a CPU stall towards the hazard unit.
// - CPU has fixed priority. AUX may lock the port for a short burst.

---
 rtl/dmem_arb_pkg.sv | 21 ++
 rtl/dmem_rsp_tag_pipe.sv | 32 +++
 rtl/dmem_arbiter.sv | 164 ++++++++++++++++
 tb/tb_dmem_arbiter.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
//   ArbState  - arbiter FSM state
//   Owner     - which requester a read response belongs to
//   rsp_tag_t - {valid, owner} carried alongside an in-flight read
//   SZ_*      - access size codes on the *Size ports
package dmem_arb_pkg;

  typedef enum logic {ARB, AUX_BURST} ArbState;

  typedef enum logic {OWN_CPU, OWN_AUX} Owner;

  typedef struct packed {
    logic valid;
    Owner owner;
  } rsp_tag_t;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

endpackage

// File: rtl/dmem_rsp_tag_pipe.sv
// Response tag pipeline: DEPTH-stage shift register of {valid, owner} tags.
// A tag pushed with an issued read emerges on head_tag exactly DEPTH cycles
// later, aligned with the memory read data.
//   clk      in  clock, rising edge
//   rst_n    in  asynchronous active-low clear (drops tags in flight)
//   push_tag in  tag for the access issued this cycle
//   head_tag out tag whose read data is on the memory bus this cycle
module dmem_rsp_tag_pipe
  import dmem_arb_pkg::*;
#(
  parameter int unsigned DEPTH = 1
) (
  input  logic     clk,
  input  logic     rst_n,
  input  rsp_tag_t push_tag,
  output rsp_tag_t head_tag
);

  rsp_tag_t stage_q [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= push_tag;
      for (int unsigned i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign head_tag = stage_q[DEPTH-1];

endmodule

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: shares one memory port between the CPU M-stage and
// an auxiliary loader/debug master. CPU has fixed priority; AUX may hold
// iAuxLock to take up to MAX_BURST consecutive beats. Read data returns
// RD_LAT cycles after issue, routed to the issuing requester.
// Optional feature macro STARVE_GUARD_EN: after AUX has waited
// STARVE_LIMIT cycles it is granted over the CPU for one cycle.
// Ports:
//   iClk, iRst                      clock, async active-low reset
//   iCpu*/oCpu*                     CPU request, ready, stall, response
//   iAux*/oAux*, iAuxLock           AUX request, ready, response, burst lock
//   oMem*                           memory request (zero when idle)
//   iMemRData                       memory read data, RD_LAT after issue
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned RD_LAT       = 1,
  parameter int unsigned MAX_BURST    = 4,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic              iClk,
  input  logic              iRst,
  input  logic              iCpuValid,
  input  logic              iCpuWrite,
  input  logic [1:0]        iCpuSize,
  input  logic [ADDR_W-1:0] iCpuAddr,
  input  logic [DATA_W-1:0] iCpuWData,
  output logic              oCpuReady,
  output logic              oCpuStall,
  output logic              oCpuRspValid,
  output logic [DATA_W-1:0] oCpuRData,
  input  logic              iAuxValid,
  input  logic              iAuxWrite,
  input  logic [1:0]        iAuxSize,
  input  logic [ADDR_W-1:0] iAuxAddr,
  input  logic [DATA_W-1:0] iAuxWData,
  input  logic              iAuxLock,
  output logic              oAuxReady,
  output logic              oAuxRspValid,
  output logic [DATA_W-1:0] oAuxRData,
  output logic              oMemEn,
  output logic              oMemWrite,
  output logic [1:0]        oMemSize,
  output logic [ADDR_W-1:0] oMemAddr,
  output logic [DATA_W-1:0] oMemWData,
  input  logic [DATA_W-1:0] iMemRData
);

  localparam int unsigned BCNT_W = $clog2(MAX_BURST + 1);

  ArbState           state_q, state_d;
  logic [BCNT_W-1:0] burst_q, burst_d;
  logic              cpu_grant, aux_grant;
  logic              force_aux;
  rsp_tag_t          push_tag, head_tag;

`ifdef STARVE_GUARD_EN
  localparam int unsigned SCNT_W = $clog2(STARVE_LIMIT + 1);

  logic [SCNT_W-1:0] starve_q;

  assign force_aux = iAuxValid && (starve_q >= SCNT_W'(STARVE_LIMIT));

  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      starve_q <= '0;
    end else if (aux_grant) begin
      starve_q <= '0;
    end else if (iAuxValid) begin
      starve_q <= starve_q + 1'b1;
    end
  end
`else
  logic unused_starve_limit;
  assign unused_starve_limit = (STARVE_LIMIT != 0);
  assign force_aux = 1'b0;
`endif

  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      state_q <= ARB;
      burst_q <= '0;
    end else begin
      state_q <= state_d;
      burst_q <= burst_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    burst_d   = burst_q;
    cpu_grant = 1'b0;
    aux_grant = 1'b0;
    unique case (state_q)
      ARB: begin
        if (force_aux)      aux_grant = 1'b1;
        else if (iCpuValid) cpu_grant = 1'b1;
        else if (iAuxValid) aux_grant = 1'b1;
        // The granting beat is the first of the burst.
        if (aux_grant && iAuxLock && (MAX_BURST > 1)) begin
          state_d = AUX_BURST;
          burst_d = BCNT_W'(1);
        end
      end
      AUX_BURST: begin
        aux_grant = iAuxValid;
        burst_d   = burst_q + 1'b1;
        if (!iAuxLock || !iAuxValid || (burst_q + 1'b1 == BCNT_W'(MAX_BURST))) begin
          state_d = ARB;
          burst_d = '0;
        end
      end
      default: state_d = ARB;
    endcase
    // Outputs are combinational from the inputs, so hold them quiet while
    // reset is asserted.
    if (!iRst) begin
      cpu_grant = 1'b0;
      aux_grant = 1'b0;
    end
  end

  assign oCpuReady = cpu_grant;
  assign oAuxReady = aux_grant;
  assign oCpuStall = iRst && iCpuValid && !cpu_grant;
  assign oMemEn    = cpu_grant || aux_grant;

  always_comb begin
    oMemWrite = 1'b0;
    oMemSize  = '0;
    oMemAddr  = '0;
    oMemWData = '0;
    if (cpu_grant) begin
      oMemWrite = iCpuWrite;
      oMemSize  = iCpuSize;
      oMemAddr  = iCpuAddr;
      oMemWData = iCpuWData;
    end else if (aux_grant) begin
      oMemWrite = iAuxWrite;
      oMemSize  = iAuxSize;
      oMemAddr  = iAuxAddr;
      oMemWData = iAuxWData;
    end
  end

  assign push_tag.valid = oMemEn && !oMemWrite;
  assign push_tag.owner = aux_grant ? OWN_AUX : OWN_CPU;

  dmem_rsp_tag_pipe #(
    .DEPTH (RD_LAT)
  ) u_tag_pipe (
    .clk      (iClk),
    .rst_n    (iRst),
    .push_tag (push_tag),
    .head_tag (head_tag)
  );

  assign oCpuRspValid = head_tag.valid && (head_tag.owner == OWN_CPU);
  assign oAuxRspValid = head_tag.valid && (head_tag.owner == OWN_AUX);
  assign oCpuRData    = oCpuRspValid ? iMemRData : '0;
  assign oAuxRData    = oAuxRspValid ? iMemRData : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;
  import dmem_arb_pkg::*;

  localparam int unsigned RD_LAT       = 2;
  localparam int unsigned MAX_BURST    = 4;
  localparam int unsigned STARVE_LIMIT = 8;
  localparam int          LOG_N        = 4096;

  logic        iClk, iRst;
  logic        iCpuValid, iCpuWrite;
  logic [1:0]  iCpuSize;
  logic [31:0] iCpuAddr, iCpuWData;
  logic        oCpuReady, oCpuStall, oCpuRspValid;
  logic [31:0] oCpuRData;
  logic        iAuxValid, iAuxWrite, iAuxLock;
  logic [1:0]  iAuxSize;
  logic [31:0] iAuxAddr, iAuxWData;
  logic        oAuxReady, oAuxRspValid;
  logic [31:0] oAuxRData;
  logic        oMemEn, oMemWrite;
  logic [1:0]  oMemSize;
  logic [31:0] oMemAddr, oMemWData;
  logic [31:0] iMemRData;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  dmem_arbiter #(
    .ADDR_W       (32),
    .DATA_W       (32),
    .RD_LAT       (RD_LAT),
    .MAX_BURST    (MAX_BURST),
    .STARVE_LIMIT (STARVE_LIMIT)
  ) dut (
    .iClk         (iClk),
    .iRst         (iRst),
    .iCpuValid    (iCpuValid),
    .iCpuWrite    (iCpuWrite),
    .iCpuSize     (iCpuSize),
    .iCpuAddr     (iCpuAddr),
    .iCpuWData    (iCpuWData),
    .oCpuReady    (oCpuReady),
    .oCpuStall    (oCpuStall),
    .oCpuRspValid (oCpuRspValid),
    .oCpuRData    (oCpuRData),
    .iAuxValid    (iAuxValid),
    .iAuxWrite    (iAuxWrite),
    .iAuxSize     (iAuxSize),
    .iAuxAddr     (iAuxAddr),
    .iAuxWData    (iAuxWData),
    .iAuxLock     (iAuxLock),
    .oAuxReady    (oAuxReady),
    .oAuxRspValid (oAuxRspValid),
    .oAuxRData    (oAuxRData),
    .oMemEn       (oMemEn),
    .oMemWrite    (oMemWrite),
    .oMemSize     (oMemSize),
    .oMemAddr     (oMemAddr),
    .oMemWData    (oMemWData),
    .iMemRData    (iMemRData)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  // Memory contents as seen by reads.
  function automatic logic [31:0] mem_func(input logic [31:0] a);
    if (a == 32'h100) return 32'hDEADBEEF;
    return {a[15:0], ~a[15:0]};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%h expected=%h", nm, cyc, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    int          due;
    bit          aux;
    logic [31:0] addr;
  } rsp_t;

  rsp_t        rspq[$];
  int          beats_left = 0;   // further AUX beats allowed in the current burst
  int          aux_wait   = 0;   // cycles AUX has waited without a grant
  bit          rd_log_v    [LOG_N];
  logic [31:0] rd_log_addr [LOG_N];

  always @(negedge iClk) begin
    bit          eg_c, eg_a, e_rc, e_ra;
    logic [31:0] e_addr, e_wd, e_rdc, e_rda;
    logic [1:0]  e_sz;
    bit          e_wr;
    if (cyc < LOG_N) rd_log_v[cyc] = 1'b0;
    if (!iRst) begin
      beats_left = 0;
      aux_wait   = 0;
      rspq.delete();
      chk("rst_cpu_ready", {63'd0, oCpuReady}, 64'd0);
      chk("rst_aux_ready", {63'd0, oAuxReady}, 64'd0);
      chk("rst_cpu_stall", {63'd0, oCpuStall}, 64'd0);
      chk("rst_cpu_rsp", {63'd0, oCpuRspValid}, 64'd0);
      chk("rst_aux_rsp", {63'd0, oAuxRspValid}, 64'd0);
      chk("rst_mem_bus", {oMemEn, oMemWrite, oMemSize, oMemAddr}, 64'd0);
      chk("rst_mem_wdata", {32'd0, oMemWData}, 64'd0);
      chk("rst_rdata", {oCpuRData, oAuxRData}, 64'd0);
    end else begin
      eg_c = 1'b0;
      eg_a = 1'b0;
      if (beats_left > 0) eg_a = iAuxValid;
`ifdef STARVE_GUARD_EN
      else if (iAuxValid && aux_wait >= STARVE_LIMIT) eg_a = 1'b1;
`endif
      else if (iCpuValid) eg_c = 1'b1;
      else if (iAuxValid) eg_a = 1'b1;

      e_wr = 1'b0; e_sz = 2'd0; e_addr = 32'd0; e_wd = 32'd0;
      if (eg_c) begin
        e_wr = iCpuWrite; e_sz = iCpuSize; e_addr = iCpuAddr; e_wd = iCpuWData;
      end else if (eg_a) begin
        e_wr = iAuxWrite; e_sz = iAuxSize; e_addr = iAuxAddr; e_wd = iAuxWData;
      end

      e_rc = 1'b0; e_ra = 1'b0; e_rdc = 32'd0; e_rda = 32'd0;
      if (rspq.size() > 0 && rspq[0].due == cyc) begin
        if (rspq[0].aux) begin e_ra = 1'b1; e_rda = mem_func(rspq[0].addr); end
        else begin e_rc = 1'b1; e_rdc = mem_func(rspq[0].addr); end
        void'(rspq.pop_front());
      end

      chk("cpu_ready", {63'd0, oCpuReady}, {63'd0, eg_c});
      chk("aux_ready", {63'd0, oAuxReady}, {63'd0, eg_a});
      chk("cpu_stall", {63'd0, oCpuStall}, {63'd0, iCpuValid && !eg_c});
      chk("mem_en", {63'd0, oMemEn}, {63'd0, eg_c || eg_a});
      chk("mem_write", {63'd0, oMemWrite}, {63'd0, e_wr});
      chk("mem_size", {62'd0, oMemSize}, {62'd0, e_sz});
      chk("mem_addr", {32'd0, oMemAddr}, {32'd0, e_addr});
      chk("mem_wdata", {32'd0, oMemWData}, {32'd0, e_wd});
      chk("cpu_rsp_valid", {63'd0, oCpuRspValid}, {63'd0, e_rc});
      chk("cpu_rdata", {32'd0, oCpuRData}, {32'd0, e_rdc});
      chk("aux_rsp_valid", {63'd0, oAuxRspValid}, {63'd0, e_ra});
      chk("aux_rdata", {32'd0, oAuxRData}, {32'd0, e_rda});

      if ((eg_c || eg_a) && !e_wr) begin
        rspq.push_back('{due: cyc + RD_LAT, aux: eg_a, addr: e_addr});
        if (cyc < LOG_N) begin
          rd_log_v[cyc]    = 1'b1;
          rd_log_addr[cyc] = e_addr;
        end
      end

      if (beats_left > 0) begin
        if (iAuxValid) beats_left--;
        if (!iAuxValid || !iAuxLock) beats_left = 0;
      end else if (eg_a && iAuxLock) begin
        beats_left = MAX_BURST - 1;
      end

      if (eg_a) aux_wait = 0;
      else if (iAuxValid) aux_wait++;
    end
    cyc++;
  end

  // Memory: returns read data RD_LAT cycles after issue, junk otherwise.
  always @(posedge iClk) begin
    #1;
    if (cyc >= RD_LAT && cyc - RD_LAT < LOG_N && rd_log_v[cyc - RD_LAT])
      iMemRData = mem_func(rd_log_addr[cyc - RD_LAT]);
    else
      iMemRData = $urandom;
  end

  // ---------------- stimulus ----------------
  task automatic cpu_req(input bit v, input bit w, input logic [1:0] sz,
                         input logic [31:0] a, input logic [31:0] d);
    iCpuValid = v; iCpuWrite = w; iCpuSize = sz; iCpuAddr = a; iCpuWData = d;
  endtask

  task automatic aux_req(input bit v, input bit w, input logic [1:0] sz,
                         input logic [31:0] a, input logic [31:0] d, input bit lk);
    iAuxValid = v; iAuxWrite = w; iAuxSize = sz; iAuxAddr = a; iAuxWData = d; iAuxLock = lk;
  endtask

  task automatic idle();
    cpu_req(0, 0, SZ_BYTE, 32'd0, 32'd0);
    aux_req(0, 0, SZ_BYTE, 32'd0, 32'd0, 0);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge iClk);
      #1;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog cyc=%0d got=timeout expected=finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int ci;
    bit exp_aux, exp_stall;
    iRst = 1'b0;
    iMemRData = 32'd0;
    idle();
    step(2);
    iRst = 1'b1;
    step(1);

    // Reset in the middle of a CPU read: the response must never appear.
    cpu_req(1, 0, SZ_WORD, 32'h40, 32'd0);
    #1 chk("lit_rst_issue_addr", {32'd0, oMemAddr}, 64'h40);
    step(1);
    cpu_req(1, 0, SZ_WORD, 32'h44, 32'd0);
    iRst = 1'b0;
    #1 chk("lit_rst_ready_low", {63'd0, oCpuReady}, 64'd0);
    step(1);
    idle();
    iRst = 1'b1;
    #1 chk("lit_rst_no_rsp", {63'd0, oCpuRspValid}, 64'd0);
    step(3);

    // Contention: CPU wins, AUX next; responses in issue order.
    cpu_req(1, 0, SZ_WORD, 32'h10, 32'd0);
    aux_req(1, 0, SZ_WORD, 32'h200, 32'd0, 0);
    #1 chk("lit_cont_addr_cpu", {32'd0, oMemAddr}, 64'h10);
    chk("lit_cont_aux_wait", {63'd0, oAuxReady}, 64'd0);
    step(1);
    cpu_req(0, 0, SZ_BYTE, 32'd0, 32'd0);
    #1 chk("lit_cont_addr_aux", {32'd0, oMemAddr}, 64'h200);
    step(1);
    idle();
    #1 chk("lit_cont_cpu_rsp", {31'd0, oCpuRspValid, oCpuRData}, {31'd0, 1'b1, 32'h0010FFEF});
    step(1);
    #1 chk("lit_cont_aux_rsp", {31'd0, oAuxRspValid, oAuxRData}, {31'd0, 1'b1, 32'h0200FDFF});
    step(2);

    // Read latency: AUX read at 0x100 returns exactly RD_LAT=2 cycles later.
    aux_req(1, 0, SZ_WORD, 32'h100, 32'd0, 0);
    #1 chk("lit_lat_grant", {63'd0, oAuxReady}, 64'd1);
    step(1);
    idle();
    #1 chk("lit_lat_early", {63'd0, oAuxRspValid}, 64'd0);
    step(1);
    #1 chk("lit_lat_data", {31'd0, oAuxRspValid, oAuxRData}, {31'd0, 1'b1, 32'hDEADBEEF});
    chk("lit_lat_cpu_quiet", {63'd0, oCpuRspValid}, 64'd0);
    step(1);
    #1 chk("lit_lat_single", {63'd0, oAuxRspValid}, 64'd0);
    step(2);

    // Burst: AUX locks the port for MAX_BURST beats, then CPU, then AUX.
    // Grants by cycle: A A A A C A ; CPU requests from cycle 1.
    begin
      logic [31:0] aaddr;
      aaddr = 32'h300;
      for (int i = 0; i < 6; i++) begin
        exp_aux   = (i != 4);
        exp_stall = (i >= 1 && i <= 3);
        aux_req(1, 0, SZ_WORD, aaddr, 32'd0, 1);
        if (i >= 1 && i <= 4) cpu_req(1, 0, SZ_HALF, 32'h20, 32'd0);
        else cpu_req(0, 0, SZ_BYTE, 32'd0, 32'd0);
        #1 chk("lit_burst_aux_grant", {63'd0, oAuxReady}, {63'd0, exp_aux});
        chk("lit_burst_cpu_stall", {63'd0, oCpuStall}, {63'd0, exp_stall});
        if (exp_aux) aaddr = aaddr + 32'd4;
        step(1);
      end
      idle();
      step(4);
    end

    // Starvation: CPU requests every cycle, AUX waits from cycle 1.
    ci = 0;
    for (int i = 1; i <= 10; i++) begin
`ifdef STARVE_GUARD_EN
      exp_aux = (i == 9);
`else
      exp_aux = 1'b0;
`endif
      cpu_req(1, 1, SZ_WORD, 32'h1000 + 32'(ci) * 4, 32'(ci));
      aux_req(1, 0, SZ_WORD, 32'h400, 32'd0, 0);
      #1 chk("lit_starve_aux", {63'd0, oAuxReady}, {63'd0, exp_aux});
      chk("lit_starve_stall", {63'd0, oCpuStall}, {63'd0, exp_aux});
      if (!exp_aux) ci++;
      step(1);
    end
    cpu_req(0, 0, SZ_BYTE, 32'd0, 32'd0);
    step(1);
    idle();
    step(4);

    // CPU byte store: issued at once, no response.
    cpu_req(1, 1, SZ_BYTE, 32'h23, 32'hAB);
    #1 chk("lit_store_bus", {oMemEn, oMemWrite, oMemSize, oMemAddr}, {30'd0, 2'b11, 2'b00, 32'h23});
    chk("lit_store_wdata", {32'd0, oMemWData}, 64'hAB);
    step(1);
    idle();
    step(1);
    #1 chk("lit_store_no_rsp", {62'd0, oCpuRspValid, oAuxRspValid}, 64'd0);
    step(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
